controlador_entradas: RTL and testbench
=======================================

CONTROLADOR_ENTRADAS -- requirements
Module: controlador_entradas

Interface
REQ-001 The block SHALL take parameter DB_CYCLES, default 4: number of consecutive synchronized-high cycles that qualify a button press.
REQ-002 The block SHALL take parameter LONG_CYCLES, default 20: number of qualified-press cycles after which a press counts as long; SHALL be greater than DB_CYCLES.
REQ-003 The block SHALL take parameter TIMEOUT_CYCLES, default 30: number of consecutive synchronized-low presence cycles before auto-off.
REQ-004 clk input 1: single clock; all logic on its rising edge.
REQ-005 rst input 1: reset, synchronous, active-high.
REQ-006 push input 1: raw asynchronous push-button level, 1 = pressed.
REQ-007 ir input 1: raw asynchronous infrared presence level, 1 = presence.
REQ-008 a output 1: one-cycle pulse, mode toggle (long press), drives lamp FSM input a.
REQ-009 b output 1: one-cycle pulse, lamp toggle (short press), drives lamp FSM input b.
REQ-010 c output 1: one-cycle pulse, absence timeout, drives lamp FSM input c.
REQ-011 d output 1: level, synchronized presence, drives lamp FSM input d.

Function
REQ-012 push and ir SHALL each pass a two-flop synchronizer; push_s and ir_s equal the inputs delayed by exactly 2 clk, and all later rules use push_s/ir_s.
REQ-013 The button FSM SHALL have states B_IDLE, B_DEBOUNCE, B_PRESSED, B_HELD, plus a counter cnt_b.
REQ-014 B_IDLE: when push_s=1 -> B_DEBOUNCE, cnt_b=1; otherwise stay, cnt_b=0.
REQ-015 B_DEBOUNCE: when push_s=0 -> B_IDLE with no pulse (glitch rejected); when push_s=1 and cnt_b=DB_CYCLES-1 -> B_PRESSED, cnt_b=0; otherwise cnt_b+1.
REQ-016 B_PRESSED: when push_s=0 -> B_IDLE and b=1 for that one cycle; when push_s=1 and cnt_b=LONG_CYCLES-1 -> B_HELD and a=1 for that one cycle; otherwise cnt_b+1.
REQ-017 B_HELD: no pulses; push_s=0 -> B_IDLE.
REQ-018 a and b SHALL be registered outputs, never high in the same cycle, and each SHALL be high at most one cycle per press.
REQ-019 d SHALL equal ir_s, registered once, so d = ir delayed by 3 clk.
REQ-020 The absence counter cnt_t SHALL clear to 0 on any cycle with ir_s=1 and SHALL increment on each ir_s=0 cycle, saturating at TIMEOUT_CYCLES.
REQ-021 c SHALL pulse for exactly one cycle on the cycle after cnt_t transitions from TIMEOUT_CYCLES-1 to TIMEOUT_CYCLES; no further c pulse SHALL occur until ir_s=1 has been seen again.
REQ-022 c and d SHALL never be high in the same cycle.
REQ-023 Counter widths SHALL be $clog2(param+1) bits; no wrap-around is permitted.
REQ-024 Button and presence paths SHALL be independent; simultaneous events SHALL both be produced in the same cycle where legal (e.g. b and c together).
REQ-025 The illegal button-state encoding SHALL recover to B_IDLE with no pulse.

Reset
REQ-026 While rst=1 at a clk edge: synchronizer flops=0, button state=B_IDLE, cnt_b=0, cnt_t=TIMEOUT_CYCLES (saturated, so no c after reset), a=b=c=d=0.
REQ-027 Reset asserted mid-press or mid-timeout SHALL abort the operation with no pulse, in the cycle following the edge; a button held across reset release SHALL be treated as a new press.

Structure
REQ-028 The button state enum and the default values of DB_CYCLES, LONG_CYCLES and TIMEOUT_CYCLES SHALL live in shared package iluminacao_pkg.
REQ-029 The two-flop synchronizer SHALL be a separate sub-module sincronizador, instantiated twice.

Verification
REQ-030 push high 10 cycles then low -> exactly one b pulse 2 cycles after the push fall edge; a stays 0.
REQ-031 push high 3 cycles (less than DB_CYCLES) -> no a or b pulse.
REQ-032 push high 40 cycles -> one a pulse, 2+DB_CYCLES+LONG_CYCLES-1 cycles after the push rise edge; no b at release.
REQ-033 ir high 5 cycles then low 50 cycles -> d high for cycles 3..7; one c pulse at TIMEOUT_CYCLES+1 cycles after ir_s falls; no second c.
REQ-034 rst asserted at cycle 10 of a 30-cycle press -> a=b=0 throughout; after reset release with push still high, a new press is qualified from zero.
REQ-035 ir toggling high every 20 cycles -> c never pulses; d follows ir with a 3-cycle lag.

Source files
------------

// File: rtl/iluminacao_pkg.sv
// ============================================================================
// Module   : iluminacao_pkg
// Purpose  : Shared button-state encoding and default timing constants for
//            the lighting input controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package iluminacao_pkg;

   typedef enum logic [1:0] {
      B_IDLE     = 2'd0,
      B_DEBOUNCE = 2'd1,
      B_PRESSED  = 2'd2,
      B_HELD     = 2'd3
   } btn_state_e;

   localparam int C_DB_CYCLES      = 4;
   localparam int C_LONG_CYCLES    = 20;
   localparam int C_TIMEOUT_CYCLES = 30;

   // Counter width able to hold the value n itself without wrapping.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_entradas_if.sv
// ============================================================================
// Module   : controlador_entradas_if
// Purpose  : Raw button/presence inputs and the four lamp-FSM strobes/levels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface controlador_entradas_if;

   logic push;
   logic ir;
   logic a;
   logic b;
   logic c;
   logic d;

   modport master (
      output push,
      output ir,
      input  a,
      input  b,
      input  c,
      input  d
   );

   modport slave (
      input  push,
      input  ir,
      output a,
      output b,
      output c,
      output d
   );

endinterface

`default_nettype wire

// File: rtl/sincronizador.sv
// ============================================================================
// Module   : sincronizador
// Purpose  : Two-flop synchronizer for a raw asynchronous level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sincronizador (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/controlador_entradas.sv
// ============================================================================
// Module   : controlador_entradas
// Purpose  : Debounces the push button into short/long strobes and turns the
//            infrared presence level into a presence level plus absence timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_entradas
   import iluminacao_pkg::*;
#(
   parameter int DB_CYCLES      = C_DB_CYCLES,
   parameter int LONG_CYCLES    = C_LONG_CYCLES,
   parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   controlador_entradas_if.slave bus
);

   localparam int C_CNT_B_W = cnt_width(LONG_CYCLES);
   localparam int C_CNT_T_W = cnt_width(TIMEOUT_CYCLES);

   localparam logic [C_CNT_B_W-1:0] C_CNT_B_ONE = C_CNT_B_W'(1);
   localparam logic [C_CNT_B_W-1:0] C_DB_LAST   = C_CNT_B_W'(DB_CYCLES - 1);
   localparam logic [C_CNT_B_W-1:0] C_LONG_LAST = C_CNT_B_W'(LONG_CYCLES - 1);
   localparam logic [C_CNT_T_W-1:0] C_T_MAX     = C_CNT_T_W'(TIMEOUT_CYCLES);
   localparam logic [C_CNT_T_W-1:0] C_T_LAST    = C_CNT_T_W'(TIMEOUT_CYCLES - 1);

   logic push_s;
   logic ir_s;

   btn_state_e           state_q, state_d;
   logic [C_CNT_B_W-1:0] cnt_b_q, cnt_b_d;
   logic                 a_q, a_d;
   logic                 b_q, b_d;

   logic [C_CNT_T_W-1:0] cnt_t_q, cnt_t_d;
   logic                 hit_q, hit_d;
   logic                 c_q, c_d;
   logic                 d_q, d_d;

   sincronizador u_sync_push (
      .clk     (clk),
      .rst     (rst),
      .async_i (bus.push),
      .sync_o  (push_s)
   );

   sincronizador u_sync_ir (
      .clk     (clk),
      .rst     (rst),
      .async_i (bus.ir),
      .sync_o  (ir_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_b_d = cnt_b_q;
      a_d     = 1'b0;
      b_d     = 1'b0;
      case (state_q)
         B_IDLE: begin
            if (push_s) begin
               state_d = B_DEBOUNCE;
               cnt_b_d = C_CNT_B_ONE;
            end else begin
               cnt_b_d = '0;
            end
         end
         B_DEBOUNCE: begin
            if (!push_s) begin
               state_d = B_IDLE;
               cnt_b_d = '0;
            end else if (cnt_b_q >= C_DB_LAST) begin
               state_d = B_PRESSED;
               cnt_b_d = '0;
            end else begin
               cnt_b_d = cnt_b_q + 1'b1;
            end
         end
         B_PRESSED: begin
            if (!push_s) begin
               state_d = B_IDLE;
               cnt_b_d = '0;
               b_d     = 1'b1;
            end else if (cnt_b_q >= C_LONG_LAST) begin
               state_d = B_HELD;
               cnt_b_d = '0;
               a_d     = 1'b1;
            end else begin
               cnt_b_d = cnt_b_q + 1'b1;
            end
         end
         B_HELD: begin
            cnt_b_d = '0;
            if (!push_s) begin
               state_d = B_IDLE;
            end
         end
         default: begin
            state_d = B_IDLE;
            cnt_b_d = '0;
         end
      endcase
   end

   // hit marks the T-1 -> T step; c follows one cycle later and is dropped if
   // presence has returned meanwhile, so c and d can never coincide.
   always_comb begin
      cnt_t_d = cnt_t_q;
      if (ir_s) begin
         cnt_t_d = '0;
      end else if (cnt_t_q < C_T_MAX) begin
         cnt_t_d = cnt_t_q + 1'b1;
      end
      hit_d = !ir_s && (cnt_t_q == C_T_LAST);
      c_d   = hit_q && !ir_s;
      d_d   = ir_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= B_IDLE;
         cnt_b_q <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         cnt_t_q <= C_T_MAX;
         hit_q   <= 1'b0;
         c_q     <= 1'b0;
         d_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_b_q <= cnt_b_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_t_q <= cnt_t_d;
         hit_q   <= hit_d;
         c_q     <= c_d;
         d_q     <= d_d;
      end
   end

   assign bus.a = a_q;
   assign bus.b = b_q;
   assign bus.c = c_q;
   assign bus.d = d_q;

endmodule

`default_nettype wire

// File: tb/tb_controlador_entradas.sv
// ============================================================================
// Module   : tb_controlador_entradas
// Purpose  : Directed bench with a pulse scoreboard for controlador_entradas.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controlador_entradas;

   localparam int DB = 4;
   localparam int LG = 20;
   localparam int TO = 30;

   typedef struct {
      int         cyc;
      logic [2:0] abc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   controlador_entradas_if bus ();

   controlador_entradas #(
      .DB_CYCLES      (DB),
      .LONG_CYCLES    (LG),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   cyc         = 0;
   int   errors      = 0;
   int   checks      = 0;
   int   push_off_at = -1;
   int   ir_off_at   = -1;
   int   push_last   = -1;
   logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

   task automatic expect_pulse(input int at, input logic [2:0] abc);
      exp_t e;
      e.cyc = at;
      e.abc = abc;
      sb.push_back(e);
   endtask

   // Press first sampled at edge s and held for n edges.
   task automatic sched_press(input int s, input int n);
      if (n >= DB + LG)
         expect_pulse(s + DB + LG + 1, 3'b100);
      else if (n >= DB)
         expect_pulse(s + n + 2, 3'b010);
   endtask

   task automatic tick();
      logic [2:0] exp_abc;
      @(posedge clk);
      cyc++;
      if (rst) begin
         h2 = 1'b0; h1 = 1'b0; h0 = 1'b0;
      end else begin
         h2 = h1; h1 = h0; h0 = bus.ir;
      end
      #1;
      exp_abc = 3'b000;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            exp_abc = exp_abc | sb[i].abc;
            sb.delete(i);
         end
      end
      checks++;
      assert ({bus.a, bus.b, bus.c} === exp_abc) else begin
         errors++;
         $error("FAIL pulses cyc=%0d: observed abc=%b expected abc=%b",
                cyc, {bus.a, bus.b, bus.c}, exp_abc);
      end
      checks++;
      assert (bus.d === h2) else begin
         errors++;
         $error("FAIL presence cyc=%0d: observed d=%b expected d=%b", cyc, bus.d, h2);
      end
      if (cyc == push_off_at) bus.push = 1'b0;
      if (cyc == ir_off_at)   bus.ir   = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic press(input int n);
      bus.push    = 1'b1;
      push_last   = cyc + n;
      push_off_at = cyc + n;
      sched_press(cyc + 1, n);
   endtask

   // lo is the planned low time that follows; a timeout is due only if it is long enough.
   task automatic ir_burst(input int hi, input int lo);
      bus.ir    = 1'b1;
      ir_off_at = cyc + hi;
      if (lo >= TO + 1)
         expect_pulse(cyc + 1 + hi + TO + 2, 3'b001);
   endtask

   initial begin
      int r;
      rst      = 1'b1;
      bus.push = 1'b0;
      bus.ir   = 1'b0;
      run(3);
      checks++;
      assert ({bus.a, bus.b, bus.c, bus.d} === 4'b0000) else begin
         errors++;
         $error("FAIL reset_outputs: observed abcd=%b expected abcd=0000",
                {bus.a, bus.b, bus.c, bus.d});
      end
      rst = 1'b0;
      run(40);

      // Short press, glitch, long press and debounce/long boundaries.
      press(10);      run(20);
      press(3);       run(15);
      press(40);      run(50);
      press(DB);      run(15);
      press(DB+LG-1); run(35);
      press(DB+LG);   run(35);

      // Presence burst followed by absence timeout.
      ir_burst(5, 50); run(55);

      // Presence toggling faster than the timeout; only the final absence times out.
      for (int i = 0; i < 3; i++) begin
         ir_burst(20, (i == 2) ? 100 : 20);
         run(40);
      end
      run(25);

      // b and c land on the same cycle.
      ir_burst(2, 100); run(22);
      press(10);        run(40);

      // Reset in the middle of a press; the still-held button is a new press.
      press(30); run(9);
      rst = 1'b1;
      sb.delete();
      run(1);
      r   = cyc;
      rst = 1'b0;
      sched_press(r + 1, push_last - r);
      run(45);

      // Reset in the middle of an absence count: no timeout afterwards.
      ir_burst(3, 100); run(20);
      rst = 1'b1;
      sb.delete();
      run(1);
      rst = 1'b0;
      run(50);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed pending=%0d expected pending=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
